// File: rtl/exec_mc_ctrl.sv
// exec_mc_ctrl: execute-stage sequencer between the ID/EX and EX/MEM registers.
// Single-cycle ALU results pass straight through; multiplier ops are issued
// with a one-cycle mc_fire pulse, EX stalls until mc_valid returns, and the
// captured result is held until the EX/MEM register takes it.
//
// Optional feature macro: MC_TIMEOUT_EN
//   defined   : a WAIT watchdog forces completion with a zero result after
//               TIMEOUT_CYCLES cycles and sets the sticky mc_timeout flag.
//   undefined : no counter, WAIT holds indefinitely, mc_timeout reads 0.
//
// Handshake: ex_out_valid/mem_ready is a strict valid/ready pair. A result
// is transferred in any cycle where both are high; while ex_out_valid is
// high and mem_ready is low, ex_result is held stable and ex_stall is
// asserted. ex_result reads 0 whenever ex_out_valid is 0.
//
// The reset input is named start (asynchronous, active-low). While it is
// low every output reads 0, even if id_valid is high.
module exec_mc_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              start,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              is_mc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_ready,
    input  logic              mc_valid,
    input  logic [DATA_W-1:0] mc_result,
    output logic              mc_fire,
    output logic              ex_stall,
    output logic              ex_out_valid,
    output logic [DATA_W-1:0] ex_result,
    output logic              mc_timeout,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] res_q;
    logic              wd_expire;

`ifdef MC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // Watchdog fires on the last allowed WAIT cycle; a same-cycle mc_valid wins.
    assign wd_expire = (state == S_WAIT) && !mc_valid && (cnt == CNT_LAST);

    // WAIT-cycle counter and sticky timeout flag; flush abandons the op unflagged.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else if (flush || state != S_WAIT) begin
            cnt <= '0;
        end else if (!mc_valid) begin
            if (cnt == CNT_LAST) begin
                timeout_q <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign mc_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    // TIMEOUT_CYCLES only sizes the watchdog; without it the flag is constant 0.
    assign mc_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Sequencer state and held multiplier result; flush always returns to IDLE.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state <= S_IDLE;
            res_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (id_valid && is_mc) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mc_valid) begin
                        res_q <= mc_result;
                        state <= S_DONE;
                    end else if (wd_expire) begin
                        res_q <= '0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (mem_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode: everything is quiet during reset and in a flush cycle.
    always_comb begin
        mc_fire      = 1'b0;
        ex_stall     = 1'b0;
        ex_out_valid = 1'b0;
        ex_result    = '0;
        if (start && !flush) begin
            case (state)
                S_IDLE: begin
                    if (id_valid) begin
                        if (is_mc) begin
                            mc_fire  = 1'b1;
                            ex_stall = 1'b1;
                        end else begin
                            ex_out_valid = 1'b1;
                            ex_result    = alu_result;
                            ex_stall     = !mem_ready;
                        end
                    end
                end
                S_WAIT: begin
                    ex_stall = 1'b1;
                end
                S_DONE: begin
                    ex_out_valid = 1'b1;
                    ex_result    = res_q;
                    ex_stall     = !mem_ready;
                end
                default: begin
                    ex_stall = 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
